// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition sequencer: state codes and default widths.
package acq_pkg;

  localparam int AW_DEF = 18;
  localparam int TW_DEF = 16;

  // Codes are visible to the host through the STATE status field.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_ARM  = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } acq_state_e;

endpackage

// File: rtl/acq_trig_qual.sv
// Trigger qualifier: CLK_EN-gated rising-edge detector on the raw trigger
// plus the auto-trigger timeout counter. Decisions are combinational so the
// sequencer can register them on the same edge as the state change.
module acq_trig_qual
  import acq_pkg::*;
#(
  parameter int TW = TW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_en,
  input  logic          arm_load,      // this edge enters ARM
  input  logic          in_arm,        // currently in ARM
  input  logic          trig_in,
  input  logic          auto_en,
  input  logic [TW-1:0] auto_timeout,
  output logic          trig_hit,
  output logic          trig_forced
);

  logic          trig_prev_q, trig_prev_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          edge_hit, tmo_hit;

  // Qualified trigger: a real edge always beats a simultaneous timeout.
  always_comb begin
    edge_hit    = in_arm & clk_en & trig_in & ~trig_prev_q;
    tmo_hit     = in_arm & clk_en & auto_en & (to_cnt_q == auto_timeout);
    trig_hit    = edge_hit | tmo_hit;
    trig_forced = tmo_hit & ~edge_hit;
  end

  // History/timeout update. On ARM entry the history is seeded with the
  // present level so a trigger already high when arming does not fire.
  always_comb begin
    trig_prev_d = trig_prev_q;
    to_cnt_d    = to_cnt_q;
    if (arm_load) begin
      trig_prev_d = trig_in;
      to_cnt_d    = '0;
    end else if (in_arm && clk_en) begin
      trig_prev_d = trig_in;
      if (auto_en) to_cnt_d = to_cnt_q + TW'(1);
    end
  end

  // Qualifier state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trig_prev_q <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      trig_prev_q <= trig_prev_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: IDLE -> PRE (pre-trigger fill) -> ARM -> POST
// (post-trigger window) -> DONE (readout hold). Owns the sample RAM write
// pointer/enable, trigger position capture and the window-counter controls.
module acq_sequencer
  import acq_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int TW = TW_DEF
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          CLK_EN,
  input  logic          CMD_START,
  input  logic          CMD_STOP,
  input  logic          CMD_ACK,
  input  logic          CONT,
  input  logic          AUTO,
  input  logic [AW-1:0] PRE_DATA,
  input  logic [TW-1:0] AUTO_TIMEOUT,
  input  logic          TRIG_IN,
  input  logic          WIN_READY,
  output logic          START_WRITE,
  output logic          TRIG_EVENT,
  output logic          WE_EN,
  output logic [AW-1:0] WPTR,
  output logic [AW-1:0] TRIG_POS,
  output logic          TRIG_FORCED,
  output logic          ACQ_DONE,
  output logic [2:0]    STATE
);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] pre_cnt_q, pre_cnt_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] trig_pos_q, trig_pos_d;
  logic          start_write_q, start_write_d;
  logic          trig_event_q, trig_event_d;
  logic          we_en_q, we_en_d;
  logic          trig_forced_q, trig_forced_d;
  logic          acq_done_q, acq_done_d;

  logic          pre_done;
  logic          arm_load;
  logic          trig_hit, trig_hit_forced;

  assign arm_load = (state_q != ST_ARM) && (state_d == ST_ARM);

  acq_trig_qual #(.TW(TW)) u_trig_qual (
    .clk          (CLK),
    .rst_n        (RST_N),
    .clk_en       (CLK_EN),
    .arm_load     (arm_load),
    .in_arm       (state_q == ST_ARM),
    .trig_in      (TRIG_IN),
    .auto_en      (AUTO),
    .auto_timeout (AUTO_TIMEOUT),
    .trig_hit     (trig_hit),
    .trig_forced  (trig_hit_forced)
  );

  // Pre-fill ends when the count reaches PRE_DATA; a zero depth skips it at once.
  always_comb begin
    pre_done = (PRE_DATA == '0) || (CLK_EN && ((pre_cnt_q + AW'(1)) == PRE_DATA));
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: STOP beats everything, ACK beats START.
  always_comb begin
    state_d = state_q;
    if (CMD_STOP) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (CMD_START && !CMD_ACK) state_d = ST_PRE;
        ST_PRE:  if (pre_done)              state_d = ST_ARM;
        ST_ARM:  if (trig_hit)              state_d = ST_POST;
        ST_POST: if (WIN_READY)             state_d = ST_DONE;
        ST_DONE: if (CMD_ACK)               state_d = CONT ? ST_PRE : ST_IDLE;
        default:                            state_d = ST_IDLE;
      endcase
    end
  end

  // Registered outputs and datapath: pointer, pre counter, controls.
  always_comb begin
    pre_cnt_d     = pre_cnt_q;
    wptr_d        = wptr_q;
    trig_pos_d    = trig_pos_q;
    start_write_d = start_write_q;
    trig_event_d  = trig_event_q;
    we_en_d       = we_en_q;
    trig_forced_d = trig_forced_q;
    acq_done_d    = acq_done_q;
    if (CMD_STOP) begin
      // Abort keeps WPTR/TRIG_POS so the host can inspect a partial capture.
      start_write_d = 1'b0;
      trig_event_d  = 1'b0;
      we_en_d       = 1'b0;
      acq_done_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (state_q == ST_DONE && CMD_ACK) acq_done_d = 1'b0;
          if (state_d == ST_PRE) begin
            wptr_d        = '0;
            pre_cnt_d     = '0;
            we_en_d       = 1'b1;
            trig_forced_d = 1'b0;
            trig_pos_d    = '0;
          end
        end
        ST_PRE: begin
          if (CLK_EN) begin
            wptr_d    = wptr_q + AW'(1);
            pre_cnt_d = pre_cnt_q + AW'(1);
          end
        end
        ST_ARM: begin
          if (CLK_EN) wptr_d = wptr_q + AW'(1);
          if (trig_hit) begin
            trig_pos_d    = wptr_q;
            start_write_d = 1'b1;
            trig_event_d  = 1'b1;
            trig_forced_d = trig_hit_forced;
          end
        end
        ST_POST: begin
          if (WIN_READY) begin
            // RAM frozen: the pointer does not advance on the completing edge.
            we_en_d       = 1'b0;
            start_write_d = 1'b0;
            trig_event_d  = 1'b0;
            acq_done_d    = 1'b1;
          end else if (CLK_EN) begin
            wptr_d = wptr_q + AW'(1);
          end
        end
        default: begin
          start_write_d = 1'b0;
          trig_event_d  = 1'b0;
          we_en_d       = 1'b0;
          acq_done_d    = 1'b0;
        end
      endcase
    end
  end

  // Datapath/output registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pre_cnt_q     <= '0;
      wptr_q        <= '0;
      trig_pos_q    <= '0;
      start_write_q <= 1'b0;
      trig_event_q  <= 1'b0;
      we_en_q       <= 1'b0;
      trig_forced_q <= 1'b0;
      acq_done_q    <= 1'b0;
    end else begin
      pre_cnt_q     <= pre_cnt_d;
      wptr_q        <= wptr_d;
      trig_pos_q    <= trig_pos_d;
      start_write_q <= start_write_d;
      trig_event_q  <= trig_event_d;
      we_en_q       <= we_en_d;
      trig_forced_q <= trig_forced_d;
      acq_done_q    <= acq_done_d;
    end
  end

  assign START_WRITE = start_write_q;
  assign TRIG_EVENT  = trig_event_q;
  assign WE_EN       = we_en_q;
  assign WPTR        = wptr_q;
  assign TRIG_POS    = trig_pos_q;
  assign TRIG_FORCED = trig_forced_q;
  assign ACQ_DONE    = acq_done_q;
  assign STATE       = state_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Bench for acq_sequencer: directed capture scenarios followed by random
// host/trigger traffic, every cycle compared against a behavioural model.
module tb_acq_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, clk_en, cmd_start, cmd_stop, cmd_ack, cont, auto_en;
  logic [17:0] pre_data;
  logic [15:0] auto_timeout;
  logic        trig_in, win_ready;
  logic        start_write, trig_event, we_en, trig_forced, acq_done;
  logic [17:0] wptr, trig_pos;
  logic [2:0]  state;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model of the capture sequence.
  int          m_st;
  logic [17:0] m_wptr, m_pos;
  int          m_pfill, m_ticks;
  bit          m_sw, m_te, m_we, m_forced, m_done, m_last;

  always #5 clk = ~clk;

  acq_sequencer #(.AW(18), .TW(16)) dut (
    .CLK(clk), .RST_N(rst_n), .CLK_EN(clk_en),
    .CMD_START(cmd_start), .CMD_STOP(cmd_stop), .CMD_ACK(cmd_ack),
    .CONT(cont), .AUTO(auto_en), .PRE_DATA(pre_data), .AUTO_TIMEOUT(auto_timeout),
    .TRIG_IN(trig_in), .WIN_READY(win_ready),
    .START_WRITE(start_write), .TRIG_EVENT(trig_event), .WE_EN(we_en),
    .WPTR(wptr), .TRIG_POS(trig_pos), .TRIG_FORCED(trig_forced),
    .ACQ_DONE(acq_done), .STATE(state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic begin_capture();
    m_st = 1; m_wptr = 0; m_pfill = 0; m_we = 1; m_forced = 0; m_pos = 0;
  endtask

  // One clock of the host-visible behaviour, from the current inputs.
  task automatic model_step();
    bit leave, real_edge, timed_out;
    if (!rst_n) begin
      m_st = 0; m_wptr = 0; m_pos = 0; m_pfill = 0; m_ticks = 0; m_last = 0;
      m_sw = 0; m_te = 0; m_we = 0; m_forced = 0; m_done = 0;
      return;
    end
    if (cmd_stop) begin
      m_st = 0; m_sw = 0; m_te = 0; m_we = 0; m_done = 0;
      return;
    end
    case (m_st)
      0: if (cmd_start && !cmd_ack) begin_capture();
      1: begin
        leave = (pre_data == 0);
        if (clk_en) begin
          m_wptr++; m_pfill++;
          if (m_pfill == pre_data) leave = 1;
        end
        if (leave) begin m_st = 2; m_last = trig_in; m_ticks = 0; end
      end
      2: if (clk_en) begin
        real_edge = trig_in && !m_last;
        timed_out = auto_en && (m_ticks == auto_timeout);
        m_last = trig_in;
        if (real_edge || timed_out) begin
          m_pos = m_wptr; m_sw = 1; m_te = 1; m_forced = !real_edge; m_st = 3;
        end
        m_wptr++;
        if (auto_en) m_ticks = (m_ticks + 1) % 65536;
      end
      3: if (win_ready) begin
        m_st = 4; m_we = 0; m_sw = 0; m_te = 0; m_done = 1;
      end else if (clk_en) m_wptr++;
      4: if (cmd_ack) begin
        m_done = 0;
        if (cont) begin_capture(); else m_st = 0;
      end
      default: m_st = 0;
    endcase
  endtask

  // Advance one clock and compare every output with the model.
  task automatic tick();
    model_step();
    @(posedge clk); #1;
    chk("state", state, m_st);
    chk("wptr", wptr, m_wptr);
    chk("trig_pos", trig_pos, m_pos);
    chk("start_write", start_write, m_sw);
    chk("trig_event", trig_event, m_te);
    chk("we_en", we_en, m_we);
    chk("trig_forced", trig_forced, m_forced);
    chk("acq_done", acq_done, m_done);
  endtask

  task automatic pulse_start(); cmd_start = 1; tick(); cmd_start = 0; endtask
  task automatic pulse_stop();  cmd_stop  = 1; tick(); cmd_stop  = 0; endtask

  initial begin
    int n;
    rst_n = 0; clk_en = 1; cmd_start = 0; cmd_stop = 0; cmd_ack = 0; cont = 0;
    auto_en = 0; pre_data = 4; auto_timeout = 0; trig_in = 0; win_ready = 0;
    tick(); tick();
    rst_n = 1;
    chk("rst_state", state, 0);
    chk("rst_we", we_en, 0);
    chk("rst_sw", start_write, 0);

    // Basic capture: PRE_DATA=4, trigger on 3rd ARM cycle.
    pulse_start();
    chk("a_we_lat", we_en, 1);
    repeat (3) tick();
    chk("a_in_pre", state, 1);
    tick();
    chk("a_arm", state, 2);
    chk("a_wptr_arm", wptr, 4);
    tick(); tick();
    trig_in = 1; tick();
    chk("a_post", state, 3);
    chk("a_tpos", trig_pos, 6);
    chk("a_sw", start_write, 1);
    chk("a_te", trig_event, 1);
    chk("a_forced", trig_forced, 0);
    repeat (3) tick();
    win_ready = 1; tick(); win_ready = 0;
    chk("a_done", acq_done, 1);
    chk("a_done_st", state, 4);
    chk("a_we_off", we_en, 0);
    chk("a_wfrz", wptr, 10);
    repeat (3) tick();
    chk("a_whold", wptr, 10);

    // ACK with CONT=1 re-arms into PRE.
    cont = 1; cmd_ack = 1; trig_in = 0; tick(); cmd_ack = 0; cont = 0;
    chk("c_pre", state, 1);
    chk("c_wptr0", wptr, 0);
    chk("c_done0", acq_done, 0);
    chk("c_we", we_en, 1);

    // Reset in the middle of POST.
    repeat (4) tick();
    trig_in = 1; tick();
    chk("r_post", state, 3);
    rst_n = 0; tick(); rst_n = 1;
    chk("r_state", state, 0);
    chk("r_sw", start_write, 0);
    chk("r_we", we_en, 0);
    chk("r_done", acq_done, 0);

    // Auto trigger: timeout 10, enable every 2nd clock -> 11th ARM enable.
    trig_in = 0; pre_data = 0; auto_en = 1; auto_timeout = 10; clk_en = 0;
    pulse_start();
    tick();
    chk("b_arm", state, 2);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      clk_en = (c % 2 == 1);
      tick();
      if (clk_en) n++;
      if (state == 3) break;
    end
    chk("b_enables", n, 11);
    chk("b_forced", trig_forced, 1);
    chk("b_te", trig_event, 1);
    clk_en = 1;
    pulse_stop();
    chk("b_stop", state, 0);

    // Real edge coincides with timeout: real trigger wins.
    pre_data = 1; auto_timeout = 5;
    pulse_start(); tick();
    chk("d_arm", state, 2);
    repeat (5) tick();
    chk("d_wait", state, 2);
    trig_in = 1; tick();
    chk("d_post", state, 3);
    chk("d_forced", trig_forced, 0);
    repeat (3) tick();
    chk("d_once", state, 3);
    pulse_stop();

    // Trigger held high across ARM entry does not fire.
    auto_en = 0; pre_data = 2;
    pulse_start(); tick(); tick();
    chk("h_arm", state, 2);
    repeat (3) tick();
    chk("h_hold", state, 2);
    trig_in = 0; tick();
    chk("h_low", state, 2);
    trig_in = 1; tick();
    chk("h_fire", state, 3);
    pulse_stop();

    // STOP during ARM, then STOP+START together in IDLE.
    trig_in = 0;
    pulse_start(); tick(); tick();
    chk("s_arm", state, 2);
    pulse_stop();
    chk("s_idle", state, 0);
    chk("s_we", we_en, 0);
    chk("s_sw", start_write, 0);
    chk("s_te", trig_event, 0);
    cmd_stop = 1; cmd_start = 1; tick(); cmd_stop = 0; cmd_start = 0;
    chk("s_both", state, 0);
    chk("s_both_we", we_en, 0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst_n     = ($urandom % 500) != 0;
      clk_en    = ($urandom % 4) != 0;
      if ($urandom % 6 == 0) trig_in = ~trig_in;
      cmd_start = ($urandom % 8) == 0;
      cmd_stop  = ($urandom % 80) == 0;
      cmd_ack   = ($urandom % 6) == 0;
      cont      = $urandom % 2;
      win_ready = ($urandom % 10) == 0;
      if ($urandom % 50 == 0) auto_en = ~auto_en;
      if (m_st == 0 && ($urandom % 4) == 0) begin
        pre_data     = 18'($urandom % 6);
        auto_timeout = 16'($urandom % 8);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
